// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and emits one bit per
// clock, with a one-word holding buffer so consecutive words stream without an idle bit.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_last,
    output logic             busy
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_shifted;
    logic             xfer;
    logic             last_bit;

    assign data_ready = rst && !hold_full_q;
    assign xfer       = data_valid && data_ready;
    assign last_bit   = (cnt_q == CntLast);
    assign sh_shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    sh_d    = data_in;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (!last_bit) begin
                    sh_d  = sh_shifted;
                    cnt_d = cnt_q + CntW'(1);
                    if (xfer) begin
                        hold_d      = data_in;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // data_ready is low here, so no new word can collide with the hold move
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (xfer) begin
                    sh_d  = data_in;
                    cnt_d = '0;
                end else begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bit_valid  = (state_q == StShift);
        bit_out    = IDLE_BIT;
        if (bit_valid) begin
            bit_out = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
        end
        frame_last = bit_valid && last_bit;
        busy       = (state_q == StShift) || hold_full_q;
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: reset, streaming through the hold buffer, direct load,
// mid-word asynchronous reset, LSB-first ordering and a 101 detector model on the serial stream.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready, bit_out, bit_valid, frame_last, busy;
    logic [7:0] data_in_l = 8'h00;
    logic       data_valid_l = 1'b0;
    logic       data_ready_l, bit_out_l, bit_valid_l, frame_last_l, busy_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .frame_last (frame_last),
        .busy       (busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in_l),
        .data_valid (data_valid_l),
        .data_ready (data_ready_l),
        .bit_out    (bit_out_l),
        .bit_valid  (bit_valid_l),
        .frame_last (frame_last_l),
        .busy       (busy_l)
    );

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       rdy;
        logic       bv;
        logic       bo;
        logic       last;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic v, input logic [7:0] d, input logic r,
                                input logic bv, input logic bo, input logic l, input logic b);
        vec_t x;
        x.valid = v; x.data = d; x.rdy = r; x.bv = bv; x.bo = bo; x.last = l; x.busy = b;
        vecs.push_back(x);
    endfunction

    task automatic idle_checks(input string name);
        check({name, "_bv"},    0, 8'(bit_valid),  8'h0);
        check({name, "_bo"},    0, 8'(bit_out),    8'h0);
        check({name, "_last"},  0, 8'(frame_last), 8'h0);
        check({name, "_busy"},  0, 8'(busy),       8'h0);
    endtask

    initial begin
        logic [7:0] a5, c3, f0, word, lastm, detm;
        logic [2:0] hist;
        int         bad;
        a5 = 8'hA5; c3 = 8'h3C; f0 = 8'h0F;

        // Reset held with a word offered
        data_valid = 1'b1;
        data_in    = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_checks("rst_hold");
            check("rst_hold_rdy", i, 8'(data_ready), 8'h0);
        end
        rst = 1'b1;
        #1;
        check("rel_rdy", 0, 8'(data_ready), 8'h1);
        tick();
        data_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("ff_bv", k, 8'(bit_valid), 8'h1);
            check("ff_bo", k, 8'(bit_out), 8'h1);
            tick();
        end
        idle_checks("ff_end");

        // Back-to-back A5 then 3C through hold, then A5 with 0F on its last-bit edge
        add(1, a5, 1, 0, 0, 0, 0);
        add(1, c3, 1, 1, a5[7], 0, 1);
        for (int k = 6; k >= 1; k--) add(0, 8'h00, 0, 1, a5[k], 0, 1);
        add(0, 8'h00, 0, 1, a5[0], 1, 1);
        for (int k = 7; k >= 1; k--) add(0, 8'h00, 1, 1, c3[k], 0, 1);
        add(0, 8'h00, 1, 1, c3[0], 1, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0);
        add(1, a5, 1, 0, 0, 0, 0);
        for (int k = 7; k >= 1; k--) add(0, 8'h00, 1, 1, a5[k], 0, 1);
        add(1, f0, 1, 1, a5[0], 1, 1);
        for (int k = 7; k >= 1; k--) add(0, 8'h00, 1, 1, f0[k], 0, 1);
        add(0, 8'h00, 1, 1, f0[0], 1, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            data_valid = vecs[i].valid;
            data_in    = vecs[i].data;
            #1;
            check("vec_rdy",  i, 8'(data_ready), 8'(vecs[i].rdy));
            check("vec_bv",   i, 8'(bit_valid),  8'(vecs[i].bv));
            check("vec_bo",   i, 8'(bit_out),    8'(vecs[i].bo));
            check("vec_last", i, 8'(frame_last), 8'(vecs[i].last));
            check("vec_busy", i, 8'(busy),       8'(vecs[i].busy));
            @(posedge clk);
            #1;
        end
        data_valid = 1'b0;

        // 101 detector with overlap on an MSB-first A5 stream: hits after bits 3 and 8
        data_valid = 1'b1;
        data_in    = a5;
        tick();
        data_valid = 1'b0;
        hist = 3'b000;
        detm = 8'h00;
        for (int k = 0; k < 8; k++) begin
            hist = {hist[1:0], bit_out};
            if (k >= 2 && hist == 3'b101) detm[k] = 1'b1;
            tick();
        end
        check("det101", 0, detm, 8'b1000_0100);

        // Mid-word asynchronous reset with 3C waiting in hold
        data_valid = 1'b1;
        data_in    = a5;
        tick();
        data_in    = c3;
        tick();
        data_valid = 1'b0;
        tick();
        tick();
        check("mid_busy_pre", 0, 8'(busy), 8'h1);
        #2;
        rst = 1'b0;
        #1;
        idle_checks("mid_rst");
        check("mid_rst_rdy", 0, 8'(data_ready), 8'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rel_rdy", 0, 8'(data_ready), 8'h1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bit_valid !== 1'b0) bad++;
        end
        check("mid_no_3c", 0, 8'(bad), 8'h0);

        // LSB-first ordering
        data_valid_l = 1'b1;
        data_in_l    = 8'h01;
        tick();
        data_valid_l = 1'b0;
        word  = 8'h00;
        lastm = 8'h00;
        bad   = 0;
        for (int k = 0; k < 8; k++) begin
            word[k]  = bit_out_l;
            lastm[k] = frame_last_l;
            if (bit_valid_l !== 1'b1) bad++;
            tick();
        end
        check("lsb_word", 0, word, 8'h01);
        check("lsb_last", 0, lastm, 8'h80);
        check("lsb_bv", 0, 8'(bad), 8'h0);
        check("lsb_end_bv", 0, 8'(bit_valid_l), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
